// File: rtl/q2a03_pkg.sv
// Shared types and register addresses for the Q2A03 sprite-DMA block.
// Imported by the controller, its bus multiplexer and the bus interface.
package q2a03_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] addr16_type;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    GET   = 3'd3,
    PUT   = 3'd4
  } dma_state_t;

  localparam addr16_type DMA_REG_ADDR  = 16'h4014;
  localparam addr16_type OAM_DATA_ADDR = 16'h2004;

  // Only GET and PUT take the bus away from the core.
  function automatic logic dma_owns_bus(input dma_state_t st);
    return (st == GET) || (st == PUT);
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and bus-side signals of the sprite-DMA arbiter.
// master = core/bus environment, slave = the DMA controller.
interface oam_dma_ctrl_if;
  import q2a03_pkg::*;

  addr16_type cpu_addr;
  reg8_type   cpu_wr_data;
  logic       cpu_rdwr;
  logic       cpu_ready;
  addr16_type bus_addr;
  reg8_type   bus_wr_data;
  logic       bus_rdwr;
  reg8_type   bus_rd_data;
  logic       dma_active;

  modport master (
    output cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data,
    input  cpu_ready, bus_addr, bus_wr_data, bus_rdwr, dma_active
  );

  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_rdwr, bus_rd_data,
    output cpu_ready, bus_addr, bus_wr_data, bus_rdwr, dma_active
  );

endinterface

// File: rtl/oam_dma_busmux.sv
// Combinational bus arbitration: DMA drives the bus in GET/PUT,
// otherwise the core's signals pass straight through.
module oam_dma_busmux
  import q2a03_pkg::*;
#(
  parameter addr16_type OAM_DATA_ADDR = q2a03_pkg::OAM_DATA_ADDR
) (
  input  dma_state_t i_state,
  input  reg8_type   i_page,
  input  reg8_type   i_idx,
  input  reg8_type   i_data_latch,
  input  addr16_type i_cpu_addr,
  input  reg8_type   i_cpu_wr_data,
  input  logic       i_cpu_rdwr,
  output addr16_type o_bus_addr,
  output reg8_type   o_bus_wr_data,
  output logic       o_bus_rdwr
);

  always_comb begin
    o_bus_addr    = i_cpu_addr;
    o_bus_wr_data = i_cpu_wr_data;
    o_bus_rdwr    = i_cpu_rdwr;
    if (dma_owns_bus(i_state)) begin
      o_bus_wr_data = i_data_latch;
      if (i_state == GET) begin
        o_bus_addr = {i_page, i_idx};
        o_bus_rdwr = 1'b1;
      end else begin
        o_bus_addr = OAM_DATA_ADDR;
        o_bus_rdwr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the core, copies one 256-byte page to the
// OAM data port as alternating get/put cycles, then returns the bus.
module oam_dma_ctrl
  import q2a03_pkg::*;
#(
  parameter addr16_type DMA_REG_ADDR  = q2a03_pkg::DMA_REG_ADDR,
  parameter addr16_type OAM_DATA_ADDR = q2a03_pkg::OAM_DATA_ADDR,
  parameter logic       PHASE_INIT    = 1'b0
) (
  input logic           G_clock,
  input logic           G_reset,
  input logic           G_cycle,
  input logic           G_ready,
  oam_dma_ctrl_if.slave bus_if
);

  dma_state_t r_state;
  reg8_type   r_page;
  reg8_type   r_idx;
  reg8_type   r_data_latch;
  logic       r_parity;

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      r_state      <= IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_data_latch <= 8'h00;
      r_parity     <= PHASE_INIT;
    end else if (G_cycle) begin
      r_parity <= ~r_parity;
      unique case (r_state)
        IDLE: begin
          if (!bus_if.cpu_rdwr && (bus_if.cpu_addr == DMA_REG_ADDR)) begin
            r_page  <= bus_if.cpu_wr_data;
            r_idx   <= 8'h00;
            r_state <= HALT;
          end
        end
        HALT: begin
          // The core only stalls on a read; the first get must land on parity 0.
          if (bus_if.cpu_rdwr) begin
            r_state <= r_parity ? GET : ALIGN;
          end
        end
        ALIGN: r_state <= GET;
        GET: begin
          r_data_latch <= bus_if.bus_rd_data;
          r_state      <= PUT;
        end
        PUT: begin
          if (r_idx == 8'hFF) begin
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= GET;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_if.cpu_ready  = G_ready & (r_state == IDLE);
  assign bus_if.dma_active = (r_state != IDLE);

  oam_dma_busmux #(
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_busmux (
    .i_state      (r_state),
    .i_page       (r_page),
    .i_idx        (r_idx),
    .i_data_latch (r_data_latch),
    .i_cpu_addr   (bus_if.cpu_addr),
    .i_cpu_wr_data(bus_if.cpu_wr_data),
    .i_cpu_rdwr   (bus_if.cpu_rdwr),
    .o_bus_addr   (bus_if.bus_addr),
    .o_bus_wr_data(bus_if.bus_wr_data),
    .o_bus_rdwr   (bus_if.bus_rdwr)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: a planned-bus-cycle model predicts
// every CPU cycle's bus contents; a monitor compares at each G_cycle strobe.
module tb_oam_dma_ctrl;
  import q2a03_pkg::*;

  localparam logic PHASE_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic g_cycle = 1'b0;
  logic g_ready = 1'b0;

  always #5 clk = ~clk;

  oam_dma_ctrl_if bus_if ();
  logic [7:0] mem [0:65535];
  assign bus_if.bus_rd_data = mem[bus_if.bus_addr];

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .PHASE_INIT   (PHASE_INIT)
  ) dut (
    .G_clock(clk),
    .G_reset(rst_n),
    .G_cycle(g_cycle),
    .G_ready(g_ready),
    .bus_if (bus_if)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  data;
    logic        chk_data;
    logic        active;
    logic        ready;
  } exp_t;

  typedef struct {
    logic        pt;      // core passes through (align cycle)
    logic        is_put;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  idx;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int checks = 0;
  int failures = 0;
  bit halt_pending = 1'b0;
  logic [7:0] m_page = 8'h00;
  int unsigned m_cnt = 0;

  // Reference: once the halt read is seen, the rest of the transfer is a
  // fixed list of bus cycles queued up front.
  function automatic void model_cycle(input logic [15:0] a, input logic [7:0] d,
                                      input logic rw, input logic rdy);
    exp_t  e;
    plan_t p;
    logic  par;
    logic  act;
    act = halt_pending || (plan_q.size() != 0);
    e.addr = a; e.rdwr = rw; e.data = d; e.chk_data = !rw;
    if (plan_q.size() != 0) begin
      p = plan_q.pop_front();
      if (!p.pt) begin
        e.addr = p.addr; e.rdwr = !p.is_put; e.data = p.data; e.chk_data = p.is_put;
      end
    end
    e.active = act;
    e.ready  = rdy & !act;
    exp_q.push_back(e);
    par = PHASE_INIT ^ m_cnt[0];
    if (!act && !rw && a == 16'h4014) begin
      halt_pending = 1'b1;
      m_page = d;
    end else if (halt_pending && rw) begin
      halt_pending = 1'b0;
      if (par == 1'b0) begin
        p = '{pt: 1'b1, is_put: 1'b0, addr: 16'h0, data: 8'h0, idx: 8'h0};
        plan_q.push_back(p);
      end
      for (int k = 0; k < 256; k++) begin
        p = '{pt: 1'b0, is_put: 1'b0, addr: {m_page, 8'(k)}, data: 8'h0, idx: 8'(k)};
        plan_q.push_back(p);
        p = '{pt: 1'b0, is_put: 1'b1, addr: 16'h2004, data: mem[{m_page, 8'(k)}], idx: 8'(k)};
        plan_q.push_back(p);
      end
    end
    m_cnt++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    int gap;
    gap = $urandom_range(0, 2);
    @(negedge clk);
    bus_if.cpu_addr    = a;
    bus_if.cpu_wr_data = d;
    bus_if.cpu_rdwr    = rw;
    g_ready            = 1'($urandom_range(0, 1));
    repeat (gap) @(negedge clk);
    g_cycle = 1'b1;
    model_cycle(a, d, rw, g_ready);
    @(negedge clk);
    g_cycle = 1'b0;
  endtask

  task automatic rand_read();
    cpu_cycle(16'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic align_to(input logic par);
    if ((PHASE_INIT ^ m_cnt[0]) != par) rand_read();
  endtask

  task automatic trigger(input logic [7:0] page, input logic par);
    align_to(par);
    cpu_cycle(16'h4014, page, 1'b0);
  endtask

  task automatic run_until_idle();
    int n;
    logic rw;
    logic [15:0] a;
    n = 0;
    while ((halt_pending || plan_q.size() != 0) && n < 2000) begin
      rw = ($urandom_range(0, 5) != 0);
      a  = ($urandom_range(0, 7) == 0) ? 16'h4014 : 16'($urandom);
      cpu_cycle(a, 8'($urandom), rw);
      n++;
    end
    if (n >= 2000) chk("transfer_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_reads_until_idle();
    int n;
    n = 0;
    while ((halt_pending || plan_q.size() != 0) && n < 2000) begin
      rand_read();
      n++;
    end
    if (n >= 2000) chk("transfer_timeout", 32'(n), 32'd0);
  endtask

  // Monitor: one scoreboard pop per strobe, sampled mid-low-phase.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      #2;
      if (g_cycle && rst_n) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checks++;
          ok = (bus_if.bus_addr === e.addr) && (bus_if.bus_rdwr === e.rdwr) &&
               (bus_if.dma_active === e.active) && (bus_if.cpu_ready === e.ready) &&
               (!e.chk_data || (bus_if.bus_wr_data === e.data));
          if (!ok) begin
            failures++;
            $display("FAIL bus_cycle actual addr=%h rdwr=%b wdata=%h active=%b ready=%b required addr=%h rdwr=%b wdata=%h(chk=%b) active=%b ready=%b",
                     bus_if.bus_addr, bus_if.bus_rdwr, bus_if.bus_wr_data, bus_if.dma_active,
                     bus_if.cpu_ready, e.addr, e.rdwr, e.data, e.chk_data, e.active, e.ready);
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 256; k++) mem[{8'h03, 8'(k)}] = 8'(k) ^ 8'hA5;

    bus_if.cpu_addr    = 16'h1234;
    bus_if.cpu_wr_data = 8'h5A;
    bus_if.cpu_rdwr    = 1'b1;
    rst_n = 1'b0;
    g_ready = 1'b0;
    #1;
    chk("reset_active", 32'(bus_if.dma_active), 32'd0);
    chk("reset_addr_pass", 32'(bus_if.bus_addr), 32'h1234);
    chk("reset_ready_lo", 32'(bus_if.cpu_ready), 32'd0);
    g_ready = 1'b1;
    #1;
    chk("reset_ready_hi", 32'(bus_if.cpu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Writes/reads near the DMA register must not trigger.
    cpu_cycle(16'h4015, 8'h11, 1'b0);
    cpu_cycle(16'h4013, 8'h22, 1'b0);
    cpu_cycle(16'h4014, 8'h33, 1'b1);
    for (int i = 0; i < 6; i++) cpu_cycle(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Even-aligned trigger, page 2.
    trigger(8'h02, 1'b0);
    run_reads_until_idle();
    // Odd-aligned trigger, page 2.
    trigger(8'h02, 1'b1);
    run_reads_until_idle();
    // Data-path page 3.
    trigger(8'h03, 1'b0);
    run_reads_until_idle();
    // Delayed halt: two core writes before the halting read.
    trigger(8'h03, 1'b1);
    cpu_cycle(16'h0700, 8'h01, 1'b0);
    cpu_cycle(16'h4014, 8'h09, 1'b0);
    run_reads_until_idle();
    // Random transfers with mixed core traffic.
    for (int t = 0; t < 3; t++) begin
      trigger(8'($urandom), 1'($urandom_range(0, 1)));
      run_until_idle();
      cpu_cycle(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset while sitting in PUT with idx 0x40.
    trigger(8'h05, 1'b0);
    n = 0;
    while (!(plan_q.size() != 0 && plan_q[0].is_put && plan_q[0].idx == 8'h40) && n < 1000) begin
      rand_read();
      n++;
    end
    if (n >= 1000) chk("reset_seek_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus_if.cpu_addr = 16'hBEEF;
    bus_if.cpu_rdwr = 1'b1;
    g_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midreset_active", 32'(bus_if.dma_active), 32'd0);
    chk("midreset_addr_pass", 32'(bus_if.bus_addr), 32'hBEEF);
    chk("midreset_rdwr_pass", 32'(bus_if.bus_rdwr), 32'd1);
    chk("midreset_ready_hi", 32'(bus_if.cpu_ready), 32'd1);
    g_ready = 1'b0;
    #1;
    chk("midreset_ready_lo", 32'(bus_if.cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midreset_active_clk", 32'(bus_if.dma_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    plan_q.delete();
    halt_pending = 1'b0;
    m_cnt = 0;

    // Fresh transfer after reset to confirm parity restart.
    cpu_cycle(16'h4015, 8'h44, 1'b0);
    trigger(8'h03, 1'b1);
    run_reads_until_idle();
    cpu_cycle(16'h0000, 8'h00, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
